gen_frame_collector: RTL and testbench

- Sits directly downstream of the generator's tanh output stage. Consumes its 13x13 signed fixed-point pixel stream (valid-only, no backpressure).
- Converts each pixel from [-1,1] Q-format to uint8 [0,255] and stores whole frames in a ping-pong buffer.
- Replays each complete frame on a valid/ready stream toward the host/DMA interface.
- Isolates the backpressure-free generator pipeline from a stalling consumer.

---
 rtl/gen_frame_collector.sv | 192 +++++++++++++++++++
 tb/tb_gen_frame_collector.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_frame_collector.sv
// Converts generator Q-format pixels to uint8 and ping-pong buffers whole frames for replay on a valid/ready stream.
// Latency: input to RAM 2 cycles; first m_valid 2 cycles after a bank commits; 1 pixel/cycle while m_ready is held.
// Backpressure: input never stalls, so a frame arriving with no free bank is dropped whole (sticky overflow); GEN_COLLECT_SATCNT_EN adds sat_count.
module gen_frame_collector #(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 8,
    parameter int FRAME_PIXELS = 169,
    parameter int ADDR_W       = $clog2(FRAME_PIXELS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [7:0]                   m_data,
    output logic                         m_last,
    output logic                         frame_done,
    output logic                         overflow,
    output logic [15:0]                  sat_count
);
    localparam int TW = DATA_WIDTH + 9;
    localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1 << FRAC_BITS);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W-1:0] PENULT = ADDR_W'(FRAME_PIXELS - 2);

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rd_state_t;

    logic signed [DATA_WIDTH-1:0] x_clamp;
    logic [TW-1:0]                t_val;
    logic [7:0]                   pix;
    logic                         s1_vld;
    logic [7:0]                   s1_pix;

    logic [ADDR_W-1:0] wr_idx;
    logic              wr_bank;
    logic              drop_mode;
    logic [1:0]        bank_full;
    logic              drop_eff;
    logic              wr_en;
    logic              wr_commit;
    logic [1:0]        set_mask;
    logic [1:0]        clr_mask;

    rd_state_t         rd_state;
    logic              rd_bank;
    logic [ADDR_W-1:0] fetch_idx;
    logic [ADDR_W-1:0] out_idx;
    logic [7:0]        rd_q;
    logic              rd_release;

    logic [7:0] mem [2][FRAME_PIXELS];

    // Map [-ONE, ONE] onto [0, 255] with round-half-up.
    always_comb begin
        x_clamp = data_in;
        if (data_in > ONE)
            x_clamp = ONE;
        else if (data_in < -ONE)
            x_clamp = -ONE;
        t_val = TW'($unsigned(x_clamp + ONE)) * TW'(255);
        pix   = 8'((t_val + TW'(ONE)) >> (FRAC_BITS + 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_pix <= '0;
        end else begin
            s1_vld <= valid_in;
            s1_pix <= pix;
        end
    end

    // The drop decision uses the registered bank_full, so a bank freed this cycle still counts as full.
    assign drop_eff  = (wr_idx == '0) ? bank_full[wr_bank] : drop_mode;
    assign wr_en     = s1_vld && !drop_eff;
    assign wr_commit = wr_en && (wr_idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx     <= '0;
            wr_bank    <= 1'b0;
            drop_mode  <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wr_commit;
            if (s1_vld) begin
                if (wr_idx == '0 && bank_full[wr_bank])
                    overflow <= 1'b1;
                if (wr_idx == LAST) begin
                    wr_idx    <= '0;
                    drop_mode <= 1'b0;
                    if (!drop_eff)
                        wr_bank <= ~wr_bank;
                end else begin
                    wr_idx    <= wr_idx + 1'b1;
                    drop_mode <= drop_eff;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_bank][wr_idx] <= s1_pix;
    end

    assign set_mask   = wr_commit ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign rd_release = (rd_state == R_STREAM) && m_valid && m_ready && m_last;
    assign clr_mask   = rd_release ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bank_full <= 2'b00;
        else
            bank_full <= (bank_full & ~clr_mask) | set_mask;
    end

    // rd_q always holds the pixel after the one on m_data, so a handshake can advance without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= R_IDLE;
            rd_bank   <= 1'b0;
            fetch_idx <= '0;
            out_idx   <= '0;
            rd_q      <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        rd_q      <= mem[rd_bank][0];
                        fetch_idx <= ADDR_W'(1);
                        rd_state  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    m_data  <= rd_q;
                    m_valid <= 1'b1;
                    m_last  <= (LAST == '0);
                    out_idx <= '0;
                    if (fetch_idx <= LAST)
                        rd_q <= mem[rd_bank][fetch_idx];
                    fetch_idx <= fetch_idx + 1'b1;
                    rd_state  <= R_STREAM;
                end
                R_STREAM: begin
                    if (m_ready) begin
                        if (m_last) begin
                            m_valid   <= 1'b0;
                            m_last    <= 1'b0;
                            rd_bank   <= ~rd_bank;
                            fetch_idx <= '0;
                            out_idx   <= '0;
                            rd_state  <= R_IDLE;
                        end else begin
                            m_data  <= rd_q;
                            m_last  <= (out_idx == PENULT);
                            out_idx <= out_idx + 1'b1;
                            if (fetch_idx <= LAST)
                                rd_q <= mem[rd_bank][fetch_idx];
                            fetch_idx <= fetch_idx + 1'b1;
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

`ifdef GEN_COLLECT_SATCNT_EN
    logic s1_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sat    <= 1'b0;
            sat_count <= '0;
        end else begin
            s1_sat <= (data_in > ONE) || (data_in < -ONE);
            if (s1_vld && s1_sat && sat_count != 16'hFFFF)
                sat_count <= sat_count + 1'b1;
        end
    end
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_gen_frame_collector.sv
// Bench for gen_frame_collector: table vectors, random frames against a conversion model, stall, drop and reset sequences.
module tb_gen_frame_collector;
    localparam int NPIX = 169;
    localparam int ONE  = 256;
    localparam int NVEC = 10;

    typedef struct {
        logic [15:0] x;
        logic [7:0]  pix;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [15:0] data_in;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        frame_done;
    logic        overflow;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beats = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    int last_drive_cyc = 0;
    int sat_exp = 0;
    bit mon_en = 1'b0;
    bit rdy_rand = 1'b0;
    vec_t vec [NVEC];
    logic [8:0] exp_q [$];

    gen_frame_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_done (frame_done),
        .overflow   (overflow),
        .sat_count  (sat_count)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
        end
    endtask

    // Clamp to [-1, 1], then scale [-1, 1] onto [0, 255] rounding half up.
    function automatic logic [7:0] ref_pix(input logic [15:0] raw);
        int x;
        int q;
        x = int'($signed(raw));
        if (x > ONE) x = ONE;
        if (x < -ONE) x = -ONE;
        q = ((x + ONE) * 255 + ONE) / (2 * ONE);
        return 8'(q);
    endfunction

    function automatic logic [31:0] exp_sat();
`ifdef GEN_COLLECT_SATCNT_EN
        return (sat_exp > 65535) ? 32'hFFFF : 32'(sat_exp);
`else
        return 32'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_rand) m_ready = 1'($urandom_range(1));
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_frame(input int kind, input bit keep, input int npix);
        logic [15:0] x;
        logic [7:0]  e;
        for (int i = 0; i < npix; i++) begin
            case (kind)
                0:       x = 16'h0100;
                1:       x = (i < NVEC) ? vec[i].x : 16'h0000;
                2:       x = 16'($urandom_range(1023)) - 16'd512;
                default: x = 16'((i - 84) * 3);
            endcase
            e = (kind == 1 && i < NVEC) ? vec[i].pix : ref_pix(x);
            if (keep) exp_q.push_back({e, (i == NPIX - 1)});
            if ($signed(x) > ONE || $signed(x) < -ONE) sat_exp++;
            last_drive_cyc = cyc;
            valid_in = 1'b1;
            data_in  = x;
            step();
        end
        valid_in = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (4) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_sat_count"}, 32'(sat_count), 32'd0);
    endtask

    // Output monitor: scoreboard per beat, stall stability, and no bubble inside a frame.
    initial begin
        bit         prev_stall;
        bit         prev_hs;
        logic       prev_last;
        logic [7:0] prev_data;
        logic [8:0] e;
        prev_stall = 0; prev_hs = 0; prev_last = 0; prev_data = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0; prev_hs = 0; prev_last = 0; prev_data = 0;
            end else if (mon_en) begin
                if (frame_done) begin
                    fd_cnt++;
                    fd_cyc = cyc;
                end
                if (prev_stall)
                    check("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_last, prev_data}));
                if (prev_hs && !prev_last)
                    check("no_gap", 32'(m_valid), 32'd1);
                if (m_valid && m_ready) begin
                    beats++;
                    check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("m_data", 32'(m_data), 32'(e[8:1]));
                        check("m_last", 32'(m_last), 32'(e[0]));
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_hs    = m_valid && m_ready;
                prev_last  = m_last;
                prev_data  = m_data;
            end
        end
    end

    initial begin
        int fd0;
        int b0;
        vec[0] = '{16'hFF00, 8'd0};
        vec[1] = '{16'h0000, 8'd128};
        vec[2] = '{16'h0100, 8'd255};
        vec[3] = '{16'h0080, 8'd191};
        vec[4] = '{16'h7FFF, 8'd255};
        vec[5] = '{16'h8000, 8'd0};
        vec[6] = '{16'hFF80, 8'd64};
        vec[7] = '{16'h0001, 8'd128};
        vec[8] = '{16'hFFFF, 8'd127};
        vec[9] = '{16'h0040, 8'd159};

        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; m_ready = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");
        step();

        // One frame of +ONE, consumer always ready
        m_ready = 1'b1; fd0 = fd_cnt; b0 = beats;
        send_frame(0, 1'b1, NPIX);
        drain(1000);
        check("ones_frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);
        check("ones_frame_done_lat", 32'(fd_cyc), 32'(last_drive_cyc + 2));
        check("ones_beats", 32'(beats - b0), 32'(NPIX));
        check("ones_overflow", 32'(overflow), 32'd0);

        // Table-driven conversion reference points
        send_frame(1, 1'b1, NPIX);
        drain(1000);
        check("table_sat_count", 32'(sat_count), exp_sat());

        // Three frames into a stalled consumer: third is dropped
        m_ready = 1'b0; fd0 = fd_cnt; b0 = beats;
        for (int f = 0; f < 3; f++) begin
            send_frame(2, (f < 2), NPIX);
            idle(4);
        end
        idle(4);
        check("ovf_frame_done_cnt", 32'(fd_cnt - fd0), 32'd2);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_no_beats_stalled", 32'(beats - b0), 32'd0);
        m_ready = 1'b1;
        drain(2000);
        check("ovf_beats", 32'(beats - b0), 32'(2 * NPIX));
        check("ovf_sat_count", 32'(sat_count), exp_sat());

        // Reset with frame 1 half read and frame 2 half written
        m_ready = 1'b0;
        send_frame(2, 1'b1, NPIX);
        idle(4);
        m_ready = 1'b1;
        send_frame(2, 1'b0, 84);
        mon_en = 1'b0; rst_n = 1'b0; valid_in = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        sat_exp = 0;
        step(); step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("no_stale_beat", 32'(m_valid), 32'd0);
        end
        check("post_midreset_overflow", 32'(overflow), 32'd0);
        step();
        b0 = beats;
        send_frame(2, 1'b1, NPIX);
        drain(1000);
        check("post_midreset_beats", 32'(beats - b0), 32'(NPIX));

        // Ramp frame with random consumer stalls
        rdy_rand = 1'b1; b0 = beats;
        send_frame(3, 1'b1, NPIX);
        drain(3000);
        rdy_rand = 1'b0; m_ready = 1'b1;
        check("ramp_beats", 32'(beats - b0), 32'(NPIX));

        // Ten frames back to back, consumer always ready
        fd0 = fd_cnt; b0 = beats;
        for (int f = 0; f < 10; f++) begin
            send_frame(2, 1'b1, NPIX);
            idle(8);
        end
        drain(2000);
        check("b2b_frame_done_cnt", 32'(fd_cnt - fd0), 32'd10);
        check("b2b_beats", 32'(beats - b0), 32'(10 * NPIX));
        check("b2b_overflow", 32'(overflow), 32'd0);
        check("b2b_sat_count", 32'(sat_count), exp_sat());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
